// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } state_t;

    typedef enum logic [1:0] {
        COND_NONE  = 2'd0,
        COND_START = 2'd1,
        COND_STOP  = 2'd2
    } cond_t;

    localparam int                   BIT_CNT_W     = 4;
    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  scl_in,
    input  logic  sda_in,
    input  logic  drive_sda,
    output logic  sda,
    output logic  scl_rise,
    output logic  scl_fall,
    output cond_t cond
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl;

    assign scl = scl_sync_q[SYNC_STAGES-1];
    assign sda = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl;
        sda_prev_d = sda;
        scl_rise   = scl & ~scl_prev_q;
        scl_fall   = ~scl & scl_prev_q;
        cond       = COND_NONE;
        // Our own SDA drive never counts as a bus condition.
        if (!drive_sda && scl && scl_prev_q) begin
            if (sda_prev_q && !sda) begin
                cond = COND_START;
            end else if (!sda_prev_q && sda) begin
                cond = COND_STOP;
            end
        end
    end

    // Idle bus level is high on both lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing an auto-incrementing byte register port
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         ADDR_W      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    logic  sda, scl_rise, scl_fall;
    cond_t cond;

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d, cap_q, cap_d;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .drive_sda (sda_oe_q),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .cond      (cond)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        cap_d    = rd_en_q;
        if (wr_en_q) addr_d = addr_q + ADDR_W'(1);
        if (cap_q)   tx_d   = reg_rdata;

        if (cond == COND_STOP) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (cond == COND_START) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        rx_d  = {rx_q[6:0], sda};
                        cnt_d = cnt_q + 1'b1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (rx_q[7:1] == TARGET_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = ST_IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            addr_d  = ADDR_W'(rx_q);
                            state_d = ST_PTR_ACK;
                        end else begin
                            wdata_d = rx_q;
                            wr_en_d = 1'b1;
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // Fetch the first read byte during the ACK slot so it is ready at the fall.
                    if (scl_rise && rw_q) begin
                        rd_en_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = ST_RD;
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = ST_WR;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                ST_RD: begin
                    // cnt_q counts bits already driven onto SDA.
                    if (scl_fall) begin
                        if (cnt_q == BITS_PER_BYTE) begin
                            state_d  = ST_RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            rd_en_d = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_RD;
                        end else begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            rw_q     <= 1'b0;
            sda_oe_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            rw_q     <= rw_d;
            sda_oe_q <= sda_oe_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            cap_q    <= cap_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr_en = wr_en_q;
    assign reg_wdata = wdata_q;
    assign reg_rd_en = rd_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bus-level host model and register-file reference for i2c_target_regs
module tb_i2c_target_regs;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_h = 1'b1;
    logic       sda_h_oe = 1'b0;
    logic       sda_oe, reg_wr_en, reg_rd_en, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       sda_line;
    logic [7:0] mem [256];

    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0, rd_cnt = 0, busy_cnt = 0;
    logic [7:0] wr_a [128];
    logic [7:0] wr_d [128];
    logic [7:0] rd_a [128];

    assign sda_line  = ~(sda_h_oe | sda_oe);
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .scl_in        (scl_h),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .reg_addr      (reg_addr),
        .reg_wr_en     (reg_wr_en),
        .reg_wdata     (reg_wdata),
        .reg_rd_en     (reg_rd_en),
        .reg_rdata     (reg_rdata),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en && wr_cnt < 128) begin
                wr_a[wr_cnt] <= reg_addr;
                wr_d[wr_cnt] <= reg_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (reg_rd_en && rd_cnt < 128) begin
                rd_a[rd_cnt] <= reg_addr;
                rd_cnt <= rd_cnt + 1;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic h_start();
        clks(4); sda_h_oe = 1'b1; clks(4); scl_h = 1'b0;
    endtask

    task automatic h_rstart();
        clks(4); sda_h_oe = 1'b0; clks(4); scl_h = 1'b1;
        clks(4); sda_h_oe = 1'b1; clks(4); scl_h = 1'b0;
    endtask

    task automatic h_stop();
        clks(4); sda_h_oe = 1'b1; clks(4); scl_h = 1'b1;
        clks(4); sda_h_oe = 1'b0; clks(4);
    endtask

    task automatic h_bit(input logic b, output logic r);
        clks(4); sda_h_oe = ~b; clks(4); scl_h = 1'b1;
        clks(4); r = sda_line; clks(4); scl_h = 1'b0;
    endtask

    task automatic h_wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) h_bit(b[i], r);
        h_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic h_rbyte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            h_bit(1'b1, r);
            b[i] = r;
        end
        h_bit(~ack, r);
    endtask

    task automatic test_reset();
        checks++;
        if ({sda_oe, reg_wr_en, reg_rd_en, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {sda_oe, reg_wr_en, reg_rd_en, busy});
        end
        checks++;
        if ({reg_addr, reg_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0000", {reg_addr, reg_wdata});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
    endtask

    // Write ptr then data bytes; reference expects (ptr+i) mod 256 per byte.
    task automatic do_write(input string name, input logic [7:0] ptr, input int n,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] dat [4];
        logic [7:0] ea;
        logic       a;
        int         acks, w0;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
        w0 = wr_cnt;
        acks = 0;
        h_start();
        h_wbyte(8'h84, a); acks += int'(a);
        h_wbyte(ptr, a);   acks += int'(a);
        for (int i = 0; i < n; i++) begin
            h_wbyte(dat[i], a);
            acks += int'(a);
        end
        h_stop();
        clks(2);
        checks++;
        if (acks != n + 2) begin
            failures++;
            $display("FAIL %s_acks got=%0d exp=%0d", name, acks, n + 2);
        end
        checks++;
        if (wr_cnt - w0 != n) begin
            failures++;
            $display("FAIL %s_wr_count got=%0d exp=%0d", name, wr_cnt - w0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                ea = ptr + 8'(i);
                checks++;
                if (wr_a[w0 + i] !== ea || wr_d[w0 + i] !== dat[i]) begin
                    failures++;
                    $display("FAIL %s_wr%0d got=(%h,%h) exp=(%h,%h)", name, i,
                             wr_a[w0 + i], wr_d[w0 + i], ea, dat[i]);
                end
                mem[ea] = dat[i];
            end
        end
        checks++;
        if (busy !== 1'b0 || reg_addr !== ptr + 8'(n)) begin
            failures++;
            $display("FAIL %s_after got=(busy=%b,addr=%h) exp=(0,%h)", name, busy, reg_addr, ptr + 8'(n));
        end
    endtask

    // Set pointer, repeated START, read n bytes (host NACKs the last).
    task automatic do_read(input string name, input logic [7:0] ptr, input int n);
        logic [7:0] got, ea;
        logic       a;
        int         acks, r0;
        r0 = rd_cnt;
        acks = 0;
        h_start();
        h_wbyte(8'h84, a); acks += int'(a);
        h_wbyte(ptr, a);   acks += int'(a);
        h_rstart();
        h_wbyte(8'h85, a); acks += int'(a);
        checks++;
        if (acks != 3) begin
            failures++;
            $display("FAIL %s_acks got=%0d exp=3", name, acks);
        end
        for (int i = 0; i < n; i++) begin
            ea = ptr + 8'(i);
            h_rbyte(i != n - 1, got);
            checks++;
            if (got !== mem[ea]) begin
                failures++;
                $display("FAIL %s_byte%0d got=%h exp=%h", name, i, got, mem[ea]);
            end
        end
        clks(6);
        checks++;
        if (sda_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got=%b exp=0", name, sda_oe);
        end
        h_stop();
        clks(2);
        checks++;
        if (rd_cnt - r0 != n) begin
            failures++;
            $display("FAIL %s_rd_count got=%0d exp=%0d", name, rd_cnt - r0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rd_a[r0 + i] !== ptr + 8'(i)) begin
                    failures++;
                    $display("FAIL %s_rd_addr%0d got=%h exp=%h", name, i, rd_a[r0 + i], ptr + 8'(i));
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got=%b exp=0", name, busy);
        end
    endtask

    task automatic test_addr_nack();
        logic a;
        int   w0, r0, b0;
        w0 = wr_cnt; r0 = rd_cnt; b0 = busy_cnt;
        h_start();
        h_wbyte(8'h86, a);
        checks++;
        if (a !== 1'b0) begin
            failures++;
            $display("FAIL nack_addr got_ack=%b exp=0", a);
        end
        h_stop();
        clks(2);
        checks++;
        if (wr_cnt != w0 || rd_cnt != r0 || busy_cnt != b0) begin
            failures++;
            $display("FAIL nack_side_effects got=(%0d,%0d,%0d) exp=(0,0,0)",
                     wr_cnt - w0, rd_cnt - r0, busy_cnt - b0);
        end
    endtask

    task automatic test_stop_partial();
        logic a, r;
        int   w0;
        w0 = wr_cnt;
        h_start();
        h_wbyte(8'h84, a);
        h_wbyte(8'h50, a);
        for (int i = 0; i < 4; i++) h_bit(i[0], r);
        h_stop();
        clks(2);
        checks++;
        if (wr_cnt != w0) begin
            failures++;
            $display("FAIL partial_wr got=%0d exp=0", wr_cnt - w0);
        end
        checks++;
        if (dut.state_q !== ST_IDLE || sda_oe !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL partial_idle got=(st=%0d,oe=%b,busy=%b) exp=(%0d,0,0)",
                     dut.state_q, sda_oe, busy, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        int   w0, r0;
        mem[8'h30] = 8'h00;
        h_start();
        h_wbyte(8'h84, a);
        h_wbyte(8'h30, a);
        h_rstart();
        h_wbyte(8'h85, a);
        clks(6);
        checks++;
        if (sda_oe !== 1'b1) begin
            failures++;
            $display("FAIL midrst_driving got=%b exp=1", sda_oe);
        end
        w0 = wr_cnt; r0 = rd_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sda_oe !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release got=%b exp=0", sda_oe);
        end
        clks(3);
        scl_h = 1'b1; sda_h_oe = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(4);
        checks++;
        if (wr_cnt != w0 || rd_cnt != r0 || reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_strobes got=(%0d,%0d) exp=(0,0)", wr_cnt - w0, rd_cnt - r0);
        end
        do_write("postrst", 8'h40, 1, 8'h77, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] p;
        int         n;
        for (int k = 0; k < 3; k++) begin
            p = (k == 0) ? 8'hFE : 8'($urandom);
            n = int'($urandom_range(1, 4));
            do_write("rand_wr", p, n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            do_read("rand_rd", p, n);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        clks(3);
        test_reset();
        rst_n = 1'b1;
        clks(4);
        do_write("write", 8'h10, 2, 8'hA5, 8'h5A, 8'h00, 8'h00);
        do_read("read", 8'h20, 3);
        test_addr_nack();
        do_write("wrap", 8'hFF, 2, 8'h11, 8'h22, 8'h00, 8'h00);
        test_stop_partial();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
